// File: rtl/muxi_cs_arb.sv
// rtl/muxi_cs_arb.sv - round-robin owner arbiter and zero-latency mux for the shared parallel bus
//
// Grants one of NUM_CANALES controllers ownership of the active-low control
// bus (CS/RD/WR/A-D) and the data bus, passes the owner's signals straight
// through, keeps the bus idle for a guard interval between owners and forces
// release of an owner that holds the bus for MAX_TENENCIA cycles.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   req[N]              per-channel bus request (level, held for a transaction)
//   cs_in/rd_in/wr_in/ad_in[N]  per-channel active-low control strobes
//   oe_in[N]            per-channel data drive enable (active-high)
//   dato_in[N*LARGO]    per-channel write data, channel i at [i*LARGO +: LARGO]
//   grant[N]            registered one-hot owner indication
//   cs_out/rd_out/wr_out/ad_out, dato_out, dato_oe   bus outputs (idle unless owned)
//   ocupado             high whenever the arbiter is not idle
//   err_timeout         one-cycle pulse after a forced release
module muxi_cs_arb #(
    parameter int NUM_CANALES  = 2,
    parameter int LARGO        = 8,
    parameter int GUARDA       = 2,
    parameter int MAX_TENENCIA = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CANALES-1:0]       req,
    input  logic [NUM_CANALES-1:0]       cs_in,
    input  logic [NUM_CANALES-1:0]       rd_in,
    input  logic [NUM_CANALES-1:0]       wr_in,
    input  logic [NUM_CANALES-1:0]       ad_in,
    input  logic [NUM_CANALES-1:0]       oe_in,
    input  logic [NUM_CANALES*LARGO-1:0] dato_in,
    output logic [NUM_CANALES-1:0]       grant,
    output logic                         cs_out,
    output logic                         rd_out,
    output logic                         wr_out,
    output logic                         ad_out,
    output logic [LARGO-1:0]             dato_out,
    output logic                         dato_oe,
    output logic                         ocupado,
    output logic                         err_timeout
);

    localparam int PW = (NUM_CANALES > 1) ? $clog2(NUM_CANALES) : 1;
    localparam logic [15:0] L_MAX_M1 = 16'(MAX_TENENCIA - 1);
    localparam logic [3:0]  L_GUARDA = 4'(GUARDA);

    typedef enum logic [1:0] {LIBRE, TENENCIA, GUARDA_ST} state_t;

    state_t                  r_state, w_state_nx;
    logic [PW-1:0]           r_sel, w_sel_nx;
    logic [PW-1:0]           r_ptr, w_ptr_nx;
    logic [15:0]             r_hold, w_hold_nx;
    logic [3:0]              r_guard, w_guard_nx;
    logic [NUM_CANALES-1:0]  r_grant, w_grant_nx;
    logic                    r_err, w_err_nx;

    logic                    w_found;
    logic [PW-1:0]           w_pick;
    logic [PW-1:0]           w_cand;
    logic [PW-1:0]           w_sel_inc;
    int                      w_sum;
    logic                    w_rel;
    logic                    w_tmo;

    // First requester at or above the pointer, wrapping; scanning offsets
    // downward lets the smallest offset win.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        w_sum   = 0;
        for (int k = NUM_CANALES - 1; k >= 0; k--) begin
            w_sum = int'(r_ptr) + k;
            if (w_sum >= NUM_CANALES) begin
                w_sum = w_sum - NUM_CANALES;
            end
            w_cand = PW'(w_sum);
            if (req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    assign w_sel_inc = (r_sel == PW'(NUM_CANALES - 1)) ? '0 : r_sel + PW'(1);
    assign w_rel     = !req[r_sel] && cs_in[r_sel];
    assign w_tmo     = (MAX_TENENCIA != 0) && (r_hold == L_MAX_M1);

    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_ptr_nx   = r_ptr;
        w_hold_nx  = r_hold;
        w_guard_nx = r_guard;
        w_grant_nx = r_grant;
        w_err_nx   = 1'b0;
        case (r_state)
            LIBRE: begin
                if (w_found) begin
                    w_state_nx = TENENCIA;
                    w_sel_nx   = w_pick;
                    w_grant_nx = NUM_CANALES'(1) << w_pick;
                    w_hold_nx  = '0;
                end
            end
            TENENCIA: begin
                if (w_rel || w_tmo) begin
                    w_grant_nx = '0;
                    w_ptr_nx   = w_sel_inc;
                    w_err_nx   = !w_rel;
                    // The LIBRE cycle before the next grant is itself idle, so
                    // the guard state only covers the remaining GUARDA-1 cycles.
                    if (GUARDA >= 2) begin
                        w_state_nx = GUARDA_ST;
                        w_guard_nx = L_GUARDA;
                    end else begin
                        w_state_nx = LIBRE;
                    end
                end else begin
                    w_hold_nx = r_hold + 16'd1;
                end
            end
            GUARDA_ST: begin
                w_guard_nx = r_guard - 4'd1;
                if (r_guard <= 4'd2) begin
                    w_state_nx = LIBRE;
                end
            end
            default: begin
                w_state_nx = LIBRE;
                w_grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LIBRE;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_guard <= '0;
            r_grant <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_sel   <= w_sel_nx;
            r_ptr   <= w_ptr_nx;
            r_hold  <= w_hold_nx;
            r_guard <= w_guard_nx;
            r_grant <= w_grant_nx;
            r_err   <= w_err_nx;
        end
    end

    // Owner pass-through with no register stage; idle bus otherwise.
    always_comb begin
        cs_out   = 1'b1;
        rd_out   = 1'b1;
        wr_out   = 1'b1;
        ad_out   = 1'b1;
        dato_out = '0;
        dato_oe  = 1'b0;
        if (r_state == TENENCIA) begin
            cs_out   = cs_in[r_sel];
            rd_out   = rd_in[r_sel];
            wr_out   = wr_in[r_sel];
            ad_out   = ad_in[r_sel];
            dato_out = dato_in[int'(r_sel)*LARGO +: LARGO];
            dato_oe  = oe_in[r_sel];
        end
    end

    assign grant       = r_grant;
    assign ocupado     = (r_state != LIBRE);
    assign err_timeout = r_err;

endmodule

// File: doc/muxi_cs_arb.md
Name: muxi_cs_arb

Overview:
- Parametrised successor to the two-source chip-select mux on the RTC parallel bus.
- Arbitrates NUM_CANALES controllers (write, read, init, ...) for ownership of the shared active-low control bus (CS, RD, WR, A/D) and the data bus.
- Grants one owner at a time, round-robin; passes the owner's signals through with zero latency.
- Enforces a guard interval with the bus idle between owners, and forces release of a hung owner.

Parameters:
- NUM_CANALES, 2, number of requesting controllers (2..8).
- LARGO, 8, data bus width in bits.
- GUARDA, 2, idle cycles inserted after each release (0..15; 0 = no guard).
- MAX_TENENCIA, 255, max cycles one owner may hold the bus (0 = no limit).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req  in  NUM_CANALES  per-channel bus request, level, held for whole transaction.
- cs_in  in  NUM_CANALES  per-channel chip select, active-low.
- rd_in  in  NUM_CANALES  per-channel read strobe, active-low.
- wr_in  in  NUM_CANALES  per-channel write strobe, active-low.
- ad_in  in  NUM_CANALES  per-channel address/data select, active-low.
- oe_in  in  NUM_CANALES  per-channel data-bus drive enable, active-high.
- dato_in  in  NUM_CANALES*LARGO  per-channel write data; channel i at [i*LARGO +: LARGO].
- grant  out  NUM_CANALES  one-hot owner indication, registered.
- cs_out  out  1  bus chip select, active-low.
- rd_out  out  1  bus read strobe.
- wr_out  out  1  bus write strobe.
- ad_out  out  1  bus A/D select.
- dato_out  out  LARGO  bus write data.
- dato_oe  out  1  tristate enable for dato_out.
- ocupado  out  1  high when state is not LIBRE.
- err_timeout  out  1  one-cycle pulse on forced release.

Behaviour:
Reset (rst_n low at a rising edge, in any state):
- state LIBRE; grant=0; round-robin pointer=0; guard and hold counters=0; err_timeout=0.
- Bus outputs forced idle: cs_out, rd_out, wr_out, ad_out = 1; dato_out = 0; dato_oe = 0.
- Reset mid-transaction aborts it immediately; no guard interval is applied.

States: LIBRE, TENENCIA, GUARDA_ST.
- LIBRE: at each edge, if any req bit is high, select the first requesting channel searching upward from the pointer (wrapping modulo NUM_CANALES). grant[sel] goes high at that edge; go to TENENCIA; hold counter = 0. With no req, remain in LIBRE.
- TENENCIA, outputs: combinationally muxed from the granted channel (cs_out = cs_in[sel], etc.). dato_out = dato_in slice of sel; dato_oe = oe_in[sel]. Zero-cycle latency from channel inputs to bus.
- TENENCIA, release: req[sel] sampled low AND cs_in[sel] high at an edge. At that edge grant clears and pointer = (sel+1) mod NUM_CANALES. Go to GUARDA_ST with counter = GUARDA, or to LIBRE if GUARDA = 0.
- TENENCIA, deferred release: if req[sel] drops while cs_in[sel] is low, release is deferred. Grant is held until cs_in[sel] is sampled high.
- TENENCIA, timeout: hold counter increments each cycle in TENENCIA. If MAX_TENENCIA ≠ 0 and the counter reaches MAX_TENENCIA, force release (same transitions as a normal release) and pulse err_timeout for exactly that cycle.
- GUARDA_ST: all bus outputs idle and grant=0. Counter decrements each cycle; at 1, go to LIBRE. Requests are ignored, not lost: req is level and is re-evaluated in LIBRE.
- All outputs are idle in every state except TENENCIA.

Invariants and simultaneous events:
- grant is always zero or one-hot.
- Non-owner inputs never reach the bus.
- If the owner releases on the same edge another channel raises req, the guard interval is applied first.
- NUM_CANALES = 1: the sole channel is always selected; the pointer stays 0.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles with req=2'b11 -> grant=0, cs_out=rd_out=wr_out=ad_out=1, dato_oe=0, ocupado=0.
- Single grant and pass-through: req=2'b10, dato_in[15:8]=8'hA5, oe_in[1]=1, wr_in[1]=0 -> grant=2'b10 after 1 edge; dato_out=8'hA5, wr_out=0 in the same cycle; channel 0 toggles ignored.
- Round-robin: req=2'b11 held, each owner releases after 4 cycles, GUARDA=2 -> grants alternate 01,10,01; exactly 2 idle cycles (cs_out=1, grant=0) between each.
- Deferred release: owner drops req while cs_in=0 for 3 more cycles -> grant held until the edge after cs_in returns to 1, then guard begins.
- Timeout: MAX_TENENCIA=16, owner never drops req -> grant clears 16 cycles after assertion; err_timeout high for 1 cycle; the other channel is granted after the guard.
- Reset mid-transaction: assert rst_n=0 while in TENENCIA with cs_out=0 -> cs_out=1, grant=0 after that edge; state LIBRE; no err_timeout pulse.
